// File: rtl/pipeline_run_ctrl.sv
// Run/halt/single-step issue controller for the five-stage pipeline: adds fetch stall and
// decode flush on top of the hazard unit, drains before reporting halted, one PC breakpoint.
module pipeline_run_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run_req,
   input  logic            step_req,
   input  logic            halt_req,
   input  logic            bp_en,
   input  logic [XLEN-1:0] bp_addr,
   input  logic [XLEN-1:0] pc_f,
   input  logic            retire_valid,
   output logic            stall_f,
   output logic            flush_d,
   output logic            running,
   output logic            halted,
   output logic            bp_hit,
   output logic [XLEN-1:0] retired,
   output logic [2:0]      state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_STEP  = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam int unsigned CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_drain_cnt;
   logic            r_skip;
   logic            r_bp_hit;
   logic [XLEN-1:0] r_retired;
   logic            w_bp_match;
   logic            w_enter_issue;
   logic            w_enter_drain;

   // The skip flag lets a resume issue the instruction sitting at bp_addr.
   assign w_bp_match = (r_state == S_RUN) && bp_en && (pc_f == bp_addr) && !r_skip;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_HALT: begin
            if (step_req)
               w_state_nxt = S_STEP;
            else if (run_req)
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (halt_req || w_bp_match)
               w_state_nxt = S_DRAIN;
         end
         S_STEP:  w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (r_drain_cnt <= CW'(1))
               w_state_nxt = S_HALT;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_issue = ((r_state == S_IDLE) || (r_state == S_HALT)) &&
                          ((w_state_nxt == S_RUN) || (w_state_nxt == S_STEP));
   assign w_enter_drain = (r_state != S_DRAIN) && (w_state_nxt == S_DRAIN);

   always_comb begin
      stall_f = 1'b1;
      flush_d = 1'b1;
      case (r_state)
         S_RUN: begin
            stall_f = w_bp_match;
            flush_d = w_bp_match;
         end
         S_STEP: begin
            stall_f = 1'b0;
            flush_d = 1'b0;
         end
         default: begin
            stall_f = 1'b1;
            flush_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_drain_cnt <= DRAIN_LOAD;
         r_skip      <= 1'b0;
         r_bp_hit    <= 1'b0;
         r_retired   <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_enter_drain)
            r_drain_cnt <= DRAIN_LOAD;
         else if ((r_state == S_DRAIN) && (r_drain_cnt != '0))
            r_drain_cnt <= r_drain_cnt - CW'(1);

         if (w_enter_issue)
            r_skip <= 1'b1;
         else if (r_state == S_RUN)
            r_skip <= 1'b0;

         if (w_enter_issue)
            r_bp_hit <= 1'b0;
         else if (w_bp_match)
            r_bp_hit <= 1'b1;

         if (retire_valid)
            r_retired <= r_retired + {{(XLEN-1){1'b0}}, 1'b1};
      end
   end

   assign running = (r_state == S_RUN);
   assign halted  = (r_state == S_IDLE) || (r_state == S_HALT);
   assign bp_hit  = r_bp_hit;
   assign retired = r_retired;
   assign state   = r_state;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed table-driven bench for pipeline_run_ctrl plus hand sequences for reset and wrap.
module tb_pipeline_run_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'h10;
   logic [31:0] pc_f = 32'h0;
   logic        retire_valid = 1'b0;
   logic        stall_f, flush_d, running, halted, bp_hit;
   logic [31:0] retired;
   logic [2:0]  state;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipeline_run_ctrl #(.DRAIN_CYCLES(4), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc_f(pc_f), .retire_valid(retire_valid),
      .stall_f(stall_f), .flush_d(flush_d), .running(running), .halted(halted),
      .bp_hit(bp_hit), .retired(retired), .state(state)
   );

   typedef struct {
      logic        run, step, halt, be;
      logic [31:0] pc;
      logic        ret;
      logic        e_stall, e_flush, e_run, e_halt, e_bph;
      logic [2:0]  e_state;
      logic [31:0] e_ret;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic run, step, halt, be, input logic [31:0] pc, input logic ret,
                    input logic st, fl, rn, hl, bh, input logic [2:0] s, input logic [31:0] rt);
      vec_t x;
      x.run = run; x.step = step; x.halt = halt; x.be = be; x.pc = pc; x.ret = ret;
      x.e_stall = st; x.e_flush = fl; x.e_run = rn; x.e_halt = hl; x.e_bph = bh;
      x.e_state = s; x.e_ret = rt;
      vecs.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " state"},   {29'd0, state}, 32'd0);
      chk({tag, " stall_f"}, {31'd0, stall_f}, 32'd1);
      chk({tag, " flush_d"}, {31'd0, flush_d}, 32'd1);
      chk({tag, " halted"},  {31'd0, halted}, 32'd1);
      chk({tag, " running"}, {31'd0, running}, 32'd0);
      chk({tag, " bp_hit"},  {31'd0, bp_hit}, 32'd0);
      chk({tag, " retired"}, retired, 32'd0);
   endtask

   initial begin
      // Cycle-by-cycle script; expected values are the outputs seen during that cycle.
      v(0,0,0,0,'h00,0, 1,1,0,1,0,0,0);   // c0 idle
      v(0,0,0,0,'h00,0, 1,1,0,1,0,0,0);
      v(1,0,0,0,'h00,0, 1,1,0,1,0,0,0);   // c2 run_req
      v(0,0,0,0,'h00,0, 0,0,1,0,0,1,0);   // c3 running
      v(0,0,0,0,'h04,0, 0,0,1,0,0,1,0);
      v(0,0,0,0,'h08,1, 0,0,1,0,0,1,0);
      v(0,0,0,0,'h0C,1, 0,0,1,0,0,1,1);
      v(0,0,0,0,'h10,0, 0,0,1,0,0,1,2);   // bp disabled: no stop at 0x10
      v(0,0,0,0,'h14,0, 0,0,1,0,0,1,2);
      v(0,0,0,0,'h18,0, 0,0,1,0,0,1,2);
      v(0,0,1,0,'h1C,0, 0,0,1,0,0,1,2);   // c10 halt_req
      v(1,0,0,0,'h1C,0, 1,1,0,0,0,3,2);   // c11 drain, run_req dropped
      v(0,1,0,0,'h1C,0, 1,1,0,0,0,3,2);   // step_req dropped
      v(0,0,1,0,'h1C,0, 1,1,0,0,0,3,2);   // halt_req dropped
      v(0,0,0,0,'h1C,0, 1,1,0,0,0,3,2);
      v(0,0,0,0,'h1C,0, 1,1,0,1,0,4,2);   // c15 halted
      v(1,0,0,1,'h00,0, 1,1,0,1,0,4,2);   // c16 run with bp at 0x10
      v(0,0,0,1,'h00,0, 0,0,1,0,0,1,2);
      v(0,0,0,1,'h04,0, 0,0,1,0,0,1,2);
      v(0,0,0,1,'h08,0, 0,0,1,0,0,1,2);
      v(0,0,0,1,'h0C,0, 0,0,1,0,0,1,2);
      v(0,0,0,1,'h10,0, 1,1,1,0,0,1,2);   // c21 match: combinational stall
      v(0,0,0,1,'h10,0, 1,1,0,0,1,3,2);
      v(0,0,0,1,'h10,0, 1,1,0,0,1,3,2);
      v(0,0,0,1,'h10,0, 1,1,0,0,1,3,2);
      v(0,0,0,1,'h10,0, 1,1,0,0,1,3,2);
      v(1,0,0,1,'h10,0, 1,1,0,1,1,4,2);   // c26 halted on bp, resume
      v(0,0,0,1,'h10,0, 0,0,1,0,0,1,2);   // c27 skip: 0x10 issues, bp_hit cleared
      v(0,0,0,1,'h14,0, 0,0,1,0,0,1,2);
      v(1,0,1,1,'h18,0, 0,0,1,0,0,1,2);   // c29 halt+run together
      v(0,0,0,1,'h18,0, 1,1,0,0,0,3,2);
      v(0,0,0,1,'h18,0, 1,1,0,0,0,3,2);
      v(0,0,0,1,'h18,0, 1,1,0,0,0,3,2);
      v(0,0,0,1,'h18,0, 1,1,0,0,0,3,2);
      v(1,1,0,1,'h1C,0, 1,1,0,1,0,4,2);   // c34 step beats run
      v(0,0,0,1,'h1C,0, 0,0,0,0,0,2,2);   // c35 single issue
      v(0,0,0,1,'h1C,0, 1,1,0,0,0,3,2);
      v(0,0,0,1,'h1C,1, 1,1,0,0,0,3,2);   // retire in drain window
      v(0,0,0,1,'h1C,0, 1,1,0,0,0,3,3);
      v(0,0,0,1,'h1C,0, 1,1,0,0,0,3,3);
      v(0,0,0,1,'h1C,0, 1,1,0,1,0,4,3);   // c40 halted

      #2 rst = 1'b1;
      #1 chk_reset_vals("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         run_req = vecs[i].run; step_req = vecs[i].step; halt_req = vecs[i].halt;
         bp_en = vecs[i].be; pc_f = vecs[i].pc; retire_valid = vecs[i].ret;
         #1;
         chk($sformatf("v%0d stall_f", i), {31'd0, stall_f}, {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d flush_d", i), {31'd0, flush_d}, {31'd0, vecs[i].e_flush});
         chk($sformatf("v%0d running", i), {31'd0, running}, {31'd0, vecs[i].e_run});
         chk($sformatf("v%0d halted", i),  {31'd0, halted},  {31'd0, vecs[i].e_halt});
         chk($sformatf("v%0d bp_hit", i),  {31'd0, bp_hit},  {31'd0, vecs[i].e_bph});
         chk($sformatf("v%0d state", i),   {29'd0, state},   {29'd0, vecs[i].e_state});
         chk($sformatf("v%0d retired", i), retired, vecs[i].e_ret);
         @(negedge clk);
      end

      // Mid-cycle reset while running, then held for three cycles.
      run_req = 1'b1; step_req = 1'b0; halt_req = 1'b0; bp_en = 1'b0; retire_valid = 1'b0;
      @(negedge clk);
      run_req = 1'b0;
      #1 chk("pre-rst running", {31'd0, running}, 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals("rst-run");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rst-hold%0d state", k), {29'd0, state}, 32'd0);
      end
      rst = 1'b0;

      // Breakpoint at the very first PC: skip on cycle one, stop on cycle two, reset in drain.
      run_req = 1'b1; bp_en = 1'b1; bp_addr = 32'h10; pc_f = 32'h10;
      @(negedge clk);
      run_req = 1'b0;
      #1 chk("skip1 stall_f", {31'd0, stall_f}, 32'd0);
      @(negedge clk);
      #1 chk("match2 stall_f", {31'd0, stall_f}, 32'd1);
      @(negedge clk);
      #1 chk("drain state", {29'd0, state}, 32'd3);
      chk("drain bp_hit", {31'd0, bp_hit}, 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals("rst-drain");
      @(negedge clk);
      rst = 1'b0; bp_en = 1'b0;

      // Retire counter wrap.
      @(negedge clk);
      force dut.r_retired = 32'hFFFF_FFFF;
      #1 release dut.r_retired;
      #1 chk("wrap preset", retired, 32'hFFFF_FFFF);
      retire_valid = 1'b1;
      @(negedge clk);
      retire_valid = 1'b0;
      #1 chk("wrap to zero", retired, 32'd0);
      @(negedge clk);
      chk("wrap hold", retired, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run/halt/single-step controller for the five-stage RISC-V pipeline. It sits beside the hazard unit and gates instruction issue. Its fetch-stall and decode-flush outputs are ORed by the integrator into the pipeline's StallF and FlushD. It drains in-flight instructions before reporting halted, supports one PC breakpoint, and counts retired instructions for the display path.

## Interface
- DRAIN_CYCLES, 4, cycles spent in DRAIN so that E/M/W empty after issue stops (pipeline depth − 1)
- XLEN, 32, PC and counter width
- clk  in  1  pipeline clock (the divided clock used by all stages)
- rst  in  1  reset, asynchronous, active-high
- run_req  in  1  single-cycle pulse: start free-running issue
- step_req  in  1  single-cycle pulse: issue exactly one instruction
- halt_req  in  1  single-cycle pulse: stop issue and drain
- bp_en  in  1  breakpoint enable
- bp_addr  in  XLEN  breakpoint PC
- pc_f  in  XLEN  current fetch-stage PC
- retire_valid  in  1  writeback holds a non-bubble instruction this cycle
- stall_f  out  1  hold PC (ORed into StallF)
- flush_d  out  1  inject bubble into decode register (ORed into FlushD)
- running  out  1  state is RUN
- halted  out  1  state is IDLE or HALT
- bp_hit  out  1  sticky: last stop was caused by the breakpoint
- retired  out  XLEN  retired-instruction count, wraps modulo 2^XLEN
- state  out  3  encoded state: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALT=4

## Operation
- States and outputs:
  - IDLE: stall_f=1, flush_d=1, halted=1.
  - RUN: stall_f=0, flush_d=0, running=1 (except on a breakpoint match, below).
  - STEP: stall_f=0, flush_d=0. Lasts 1 cycle.
  - DRAIN: stall_f=1, flush_d=1. Lasts DRAIN_CYCLES cycles, counted by an internal down-counter.
  - HALT: stall_f=1, flush_d=1, halted=1.
- Transitions:
  - IDLE/HALT: run_req → RUN. step_req → STEP.
  - RUN: halt_req or breakpoint match → DRAIN.
  - STEP → DRAIN unconditionally.
  - DRAIN → HALT when the counter reaches 0.
- Request priority when several arrive in the same cycle: halt_req > step_req > run_req.
- Requests not valid in the current state are dropped, not queued: run_req and step_req in RUN, STEP or DRAIN; halt_req outside RUN.
- Breakpoint match = state RUN, bp_en=1, pc_f==bp_addr, skip flag clear.
  - On a match, stall_f and flush_d assert combinationally in the same cycle, so the instruction at bp_addr is not issued.
  - A match sets bp_hit.
- Skip flag: set on every transition into RUN or STEP, cleared after the first RUN cycle. Resuming from a breakpoint therefore issues the instruction at bp_addr instead of re-triggering.
- bp_hit is cleared on entry to RUN or STEP.
- retired increments by 1 on each cycle with retire_valid=1, in any state; it wraps from all-ones to 0.
- Pipeline-internal hazards (load-use stall, branch flush) keep operating; this block only adds stall/flush.

## Timing
- Reset values: state=IDLE, stall_f=1, flush_d=1, halted=1, running=0, bp_hit=0, retired=0, drain counter=DRAIN_CYCLES, skip flag=0.
- rst asserted in any state returns the block to IDLE immediately, without waiting for a clock edge.
- All state changes happen on rising clk. Apart from the breakpoint stall, outputs are decoded from the registered state.
- run_req at cycle n → RUN at n+1, first instruction issued at n+1.
- halt_req at cycle n → the instruction fetched at n still issues. DRAIN covers n+1 … n+DRAIN_CYCLES; HALT and halted=1 from n+DRAIN_CYCLES+1.
- Breakpoint match at cycle n → stall_f=1 at n. DRAIN from n+1; halted at n+1+DRAIN_CYCLES.
- step_req at cycle n → STEP at n+1 (one issue). DRAIN n+2 … n+1+DRAIN_CYCLES; HALT at n+2+DRAIN_CYCLES. Exactly one retire_valid is expected inside that window.
- The drain counter reloads with DRAIN_CYCLES on every DRAIN entry.

## Test plan
- Reset: assert rst mid-cycle → all outputs at reset values before the next clk edge. Hold 3 cycles → state stays 0.
- Run/halt with DRAIN_CYCLES=4: run_req at cycle 2 → running=1 at cycle 3. halt_req at cycle 10 → state=3 during cycles 11–14, halted=1 at cycle 15.
- Breakpoint: bp_en=1, bp_addr=0x10, pc_f steps 0x0,0x4,…, run → stall_f=1 in the same cycle pc_f=0x10. Then state 3 for 4 cycles, HALT, bp_hit=1.
- Resume past breakpoint: from that HALT with pc_f=0x10, run_req → no stall on the first RUN cycle, bp_hit=0, running continues with pc_f=0x14.
- Single step: from HALT, step_req → stall_f=0 for exactly 1 cycle. Drive retire_valid once in the drain window → retired increments by exactly 1, then HALT.
- Corner cases:
  - halt_req and run_req in the same cycle while in RUN → DRAIN.
  - rst during DRAIN → IDLE immediately.
  - retired preset by forcing to 0xFFFFFFFF, then one retire_valid → 0.
